// File: rtl/elevator_pkg.sv
// Shared codes and types for the elevator plant, its controller and their benches.
package elevator_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_BAD  = 2'b11;

  localparam logic [1:0] FLOOR1 = 2'b01;
  localparam logic [1:0] FLOOR2 = 2'b10;
  localparam logic [1:0] FLOOR3 = 2'b11;

  typedef enum logic [1:0] {
    DoorOpen,
    DoorClosing,
    DoorClosed,
    DoorOpening
  } door_state_t;

  // Shared width for the door and travel counters.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/elevator_door_model.sv
// Door mechanism: four-state FSM with a shared open/close timer; dc is registered.
module elevator_door_model
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_TIME = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_door,
  input  logic        i_hold_closed,
  output logic        o_dc,
  output door_state_t o_door_state
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DOOR_TIME - 1);

  door_state_t      r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_dc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DoorOpen;
      r_cnt   <= '0;
      r_dc    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_dc    <= (w_state_d == DoorClosed);
    end
  end

  // A command reversal mid-motion takes priority over completing the motion.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      DoorOpen: begin
        if (i_door) begin
          w_state_d = DoorClosing;
          w_cnt_d   = LOAD;
        end
      end
      DoorClosing: begin
        if (!i_door) begin
          w_state_d = DoorOpening;
          w_cnt_d   = LOAD;
        end else if (r_cnt == '0) begin
          w_state_d = DoorClosed;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      DoorClosed: begin
        if (!i_door && !i_hold_closed) begin
          w_state_d = DoorOpening;
          w_cnt_d   = LOAD;
        end
      end
      DoorOpening: begin
        if (i_door) begin
          w_state_d = DoorClosing;
          w_cnt_d   = LOAD;
        end else if (r_cnt == '0) begin
          w_state_d = DoorOpen;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
    endcase
  end

  assign o_dc         = r_dc;
  assign o_door_state = r_state;

endmodule

// File: rtl/elevator_plant.sv
// Elevator car/shaft/door plant: turns controller door/dir commands into fs/dc feedback
// and latches a sticky fault on any illegal command sequence.
module elevator_plant
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_TIME   = 4,
  parameter int unsigned TRAVEL_TIME = 8,
  parameter logic [1:0]  RESET_FLOOR = FLOOR1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_door,
  input  logic [1:0] i_dir,
  output logic [1:0] o_fs,
  output logic       o_dc,
  output logic       o_moving,
  output logic       o_fault
);

  localparam int unsigned      CNT_W = cnt_width(DOOR_TIME, TRAVEL_TIME);
  localparam logic [CNT_W-1:0] TLOAD = CNT_W'(TRAVEL_TIME - 1);

  logic [1:0]       r_dir_q;
  logic [1:0]       r_fs;
  logic [1:0]       r_target;
  logic             r_moving;
  logic             r_fault;
  logic [CNT_W-1:0] r_cnt;
  door_state_t      w_door_state;
  logic             w_dc;
  logic             w_rise;
  logic             w_fault_evt;
  logic             w_start;

  elevator_door_model #(
    .DOOR_TIME(DOOR_TIME),
    .CNT_W    (CNT_W)
  ) u_door (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_door       (i_door),
    .i_hold_closed(r_moving),
    .o_dc         (w_dc),
    .o_door_state (w_door_state)
  );

  assign w_rise = (r_dir_q == DIR_IDLE) && (i_dir != DIR_IDLE);

  always_comb begin
    w_fault_evt = (i_dir == DIR_BAD)
                | (w_rise && (w_door_state != DoorClosed))
                | (w_rise && (i_dir == DIR_UP) && (r_fs == FLOOR3))
                | (w_rise && (i_dir == DIR_DOWN) && (r_fs == FLOOR1))
                | (r_moving && (i_dir != r_dir_q))
                | (r_moving && !i_door);
    w_start = w_rise && (w_door_state == DoorClosed) && !r_fault && !w_fault_evt;
  end

  // Fault beats both trip start and arrival, so fs freezes on the departure floor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir_q  <= DIR_IDLE;
      r_fs     <= RESET_FLOOR;
      r_target <= RESET_FLOOR;
      r_moving <= 1'b0;
      r_fault  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_dir_q <= i_dir;
      if (w_fault_evt) begin
        r_fault  <= 1'b1;
        r_moving <= 1'b0;
      end else if (w_start) begin
        r_moving <= 1'b1;
        r_cnt    <= TLOAD;
        r_target <= (i_dir == DIR_UP) ? r_fs + 2'd1 : r_fs - 2'd1;
      end else if (r_moving) begin
        if (r_cnt == '0) begin
          r_fs     <= r_target;
          r_moving <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign o_fs     = r_fs;
  assign o_dc     = w_dc;
  assign o_moving = r_moving;
  assign o_fault  = r_fault;

endmodule

// File: tb/tb_elevator_plant.sv
// Bench for elevator_plant: event-time reference model checked every cycle, plus directed scenarios.
module tb_elevator_plant;

  localparam int D = 4;
  localparam int T = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       door  = 1'b0;
  logic [1:0] dir   = 2'b00;
  logic [1:0] fs;
  logic       dc;
  logic       moving;
  logic       fault;

  int total = 0;
  int bad   = 0;

  elevator_plant #(
    .DOOR_TIME  (D),
    .TRAVEL_TIME(T),
    .RESET_FLOOR(2'b01)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_door  (door),
    .i_dir   (dir),
    .o_fs    (fs),
    .o_dc    (dc),
    .o_moving(moving),
    .o_fault (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: door is a goal (open/closed) plus the cycle its motion completes;
  // a trip is a target floor plus its arrival cycle.
  int         m_cyc         = 0;
  int         m_floor       = 1;
  int         m_tgt         = 1;
  int         m_arrive      = 0;
  int         m_ready       = 0;
  bit         m_fault       = 1'b0;
  bit         m_trip        = 1'b0;
  bit         m_goal_closed = 1'b0;
  logic [1:0] m_prev_dir    = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_floor <= 1; m_tgt <= 1; m_arrive <= 0; m_ready <= 0;
      m_fault <= 1'b0; m_trip <= 1'b0; m_goal_closed <= 1'b0; m_prev_dir <= 2'b00;
    end else begin : upd
      bit settled, closed_now, rise, f;
      settled    = (m_cyc >= m_ready);
      closed_now = m_goal_closed && settled;
      rise       = (m_prev_dir == 2'b00) && (dir != 2'b00);
      f = (dir == 2'b11)
        || (rise && (!closed_now || (dir == 2'b01 && m_floor == 3) || (dir == 2'b10 && m_floor == 1)))
        || (m_trip && (dir != m_prev_dir || !door));
      if (f) begin
        m_fault <= 1'b1;
        m_trip  <= 1'b0;
      end else if (rise && closed_now && !m_fault) begin
        m_trip   <= 1'b1;
        m_arrive <= m_cyc + 1 + T;
        m_tgt    <= (dir == 2'b01) ? m_floor + 1 : m_floor - 1;
      end else if (m_trip && m_cyc + 1 == m_arrive) begin
        m_floor <= m_tgt;
        m_trip  <= 1'b0;
      end
      if ((!m_goal_closed && settled && door) || (!settled && (m_goal_closed != door))) begin
        m_goal_closed <= door;
        m_ready       <= m_cyc + 1 + D;
      end else if (closed_now && !door && !m_trip) begin
        m_goal_closed <= 1'b0;
        m_ready       <= m_cyc + 1 + D;
      end
      m_prev_dir <= dir;
      m_cyc      <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    check("fs", 32'(fs), 32'(m_floor));
    check("dc", 32'(dc), 32'(m_goal_closed && m_cyc >= m_ready));
    check("moving", 32'(moving), 32'(m_trip));
    check("fault", 32'(fault), 32'(m_fault));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    door = 1'b0;
    dir  = 2'b00;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic trip_up();
    dir = 2'b01;
    tick(T + 1);
    dir = 2'b00;
    tick();
  endtask

  initial begin
    // Close latency and first trip
    do_reset();
    check("rst_fs", 32'(fs), 32'd1);
    check("rst_dc", 32'(dc), 32'd0);
    door = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("close_dc", 32'(dc), (k == 5) ? 32'd1 : 32'd0);
      check("close_fault", 32'(fault), 32'd0);
    end
    tick(4);
    dir = 2'b01;
    tick();
    check("trip_moving", 32'(moving), 32'd1);
    check("trip_fs_dep", 32'(fs), 32'd1);
    tick(7);
    check("trip_moving_late", 32'(moving), 32'd1);
    tick();
    check("arrive_fs", 32'(fs), 32'd2);
    check("arrive_moving", 32'(moving), 32'd0);
    tick(10);
    check("held_dir_fs", 32'(fs), 32'd2);
    check("held_dir_moving", 32'(moving), 32'd0);
    dir = 2'b00;
    tick();

    // Reopen then reclose during OPENING
    door = 1'b0;
    tick();
    check("reopen_dc", 32'(dc), 32'd0);
    tick();
    door = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("reclose_dc", 32'(dc), (k == 5) ? 32'd1 : 32'd0);
    end

    // Request with doors open
    do_reset();
    dir = 2'b01;
    tick();
    check("open_req_fault", 32'(fault), 32'd1);
    check("open_req_moving", 32'(moving), 32'd0);
    check("open_req_fs", 32'(fs), 32'd1);
    dir = 2'b00;
    door = 1'b1;
    tick(8);
    check("fault_sticky", 32'(fault), 32'd1);

    // Up request at top floor
    do_reset();
    door = 1'b1;
    tick(6);
    trip_up();
    trip_up();
    check("top_fs", 32'(fs), 32'd3);
    check("top_fault_pre", 32'(fault), 32'd0);
    dir = 2'b01;
    tick();
    check("top_fault", 32'(fault), 32'd1);
    check("top_moving", 32'(moving), 32'd0);
    dir = 2'b00;
    tick(3);

    // dir dropped mid-trip
    do_reset();
    door = 1'b1;
    tick(6);
    dir = 2'b01;
    tick(4);
    dir = 2'b00;
    tick();
    check("drop_fault", 32'(fault), 32'd1);
    check("drop_moving", 32'(moving), 32'd0);
    tick(T);
    check("drop_fs", 32'(fs), 32'd1);

    // Asynchronous reset mid-trip
    do_reset();
    door = 1'b1;
    tick(6);
    dir = 2'b01;
    tick(4);
    check("pre_async_moving", 32'(moving), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_fs", 32'(fs), 32'd1);
    check("async_dc", 32'(dc), 32'd0);
    check("async_moving", 32'(moving), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    dir = 2'b00;
    door = 1'b0;
    tick();
    rst_n = 1'b1;

    // Randomized episodes: mostly well-behaved controller, every fourth fully random
    for (int ep = 0; ep < 40; ep++) begin
      bit sloppy;
      int age;
      sloppy = (ep % 4 == 3);
      age    = 0;
      do_reset();
      door = 1'b1;
      for (int c = 0; c < 200; c++) begin
        tick();
        if (sloppy) begin
          if ($urandom_range(9) == 0) door = ~door;
          if ($urandom_range(7) == 0) dir = 2'($urandom_range(3));
        end else begin
          age++;
          if (dir == 2'b00) begin
            if (m_goal_closed && m_cyc >= m_ready && !m_trip && $urandom_range(3) == 0) begin
              if ($urandom_range(19) == 0) dir = 2'($urandom_range(3, 1));
              else if (m_floor == 1) dir = 2'b01;
              else if (m_floor == 3) dir = 2'b10;
              else dir = ($urandom_range(1) != 0) ? 2'b01 : 2'b10;
              age = 0;
            end
          end else if (!m_trip && age >= 2) begin
            dir = 2'b00;
          end
          if (!m_trip && $urandom_range(15) == 0) door = ~door;
          else if (!door && $urandom_range(3) == 0) door = 1'b1;
          if (m_trip && $urandom_range(199) == 0) door = 1'b0;
        end
      end
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
